// File: rtl/float_argmax.sv
// Streaming IEEE-754 max/argmax: tracks the running maximum of one frame and
// reports value, first index, NaN and index-overflow status at frame end.
module float_argmax #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [EXP_W+MAN_W:0]     in_data_i,
  input  logic                     in_last_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [EXP_W+MAN_W:0]     out_max_o,
  output logic [IDX_W-1:0]         out_idx_o,
  output logic                     out_nan_o,
  output logic                     out_ovf_o
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}} | (W'(1) << (MAN_W - 1));

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e           state_q;
  logic [W-1:0]     max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             have_q, have_d;
  logic             nan_q, nan_d;
  logic             ovf_q, ovf_d;
  logic             full_q, full_d;

  logic             out_valid_q;
  logic [W-1:0]     out_max_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_nan_q;
  logic             out_ovf_q;

  logic             accept;
  logic             beat_nan;
  logic             take;

  // Monotonic unsigned key: both zeros map to the same key, negatives below
  // all positives with larger magnitude giving a smaller key.
  function automatic logic [W-1:0] order_key(input logic [W-1:0] v);
    logic [W-1:0] k;
    if (v[W-2:0] == '0)
      k = {1'b1, {(W-1){1'b0}}};
    else if (!v[W-1])
      k = {1'b1, v[W-2:0]};
    else
      k = {1'b0, ~v[W-2:0]};
    return k;
  endfunction

  assign in_ready_o = (state_q != HOLD);
  assign accept     = in_valid_i && in_ready_o;
  assign beat_nan   = (&in_data_i[W-2:MAN_W]) && (|in_data_i[MAN_W-1:0]);
  assign take       = accept && !beat_nan &&
                      (!have_q || (order_key(in_data_i) > order_key(max_q)));

  always_comb begin
    max_d  = max_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    have_d = have_q;
    nan_d  = nan_q;
    ovf_d  = ovf_q;
    full_d = full_q;
    if (accept) begin
      nan_d  = nan_q | beat_nan;
      have_d = have_q | !beat_nan;
      // cnt_q parks at all ones; full_q marks that index as already consumed
      ovf_d  = ovf_q | full_q;
      if (!full_q) begin
        if (&cnt_q) full_d = 1'b1;
        else        cnt_d  = cnt_q + IDX_W'(1);
      end
      if (take) begin
        max_d = in_data_i;
        idx_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      max_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      have_q      <= 1'b0;
      nan_q       <= 1'b0;
      ovf_q       <= 1'b0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_nan_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            max_q  <= max_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            have_q <= have_d;
            nan_q  <= nan_d;
            ovf_q  <= ovf_d;
            full_q <= full_d;
            if (in_last_i) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_max_q   <= have_d ? max_d : QNAN;
              out_idx_q   <= have_d ? idx_d : '0;
              out_nan_q   <= nan_d;
              out_ovf_q   <= ovf_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            max_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            have_q      <= 1'b0;
            nan_q       <= 1'b0;
            ovf_q       <= 1'b0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_idx_q   <= '0;
            out_nan_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_max_o   = out_max_q;
  assign out_idx_o   = out_idx_q;
  assign out_nan_o   = out_nan_q;
  assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_float_argmax.sv
// Bench for float_argmax: two instances (IDX_W=8 and IDX_W=2) share one stimulus
// stream and are checked every cycle against a real-valued frame model.
module tb_float_argmax;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        rdy_a, vld_a, nan_a, ovf_a;
  logic [31:0] max_a;
  logic [7:0]  idx_a;
  logic        rdy_b, vld_b, nan_b, ovf_b;
  logic [31:0] max_b;
  logic [1:0]  idx_b;

  int n_checks = 0;
  int n_errors = 0;

  float_argmax #(.EXP_W(8), .MAN_W(23), .IDX_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(rdy_a), .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(vld_a), .out_ready_i(out_ready), .out_max_o(max_a), .out_idx_o(idx_a),
    .out_nan_o(nan_a), .out_ovf_o(ovf_a)
  );

  float_argmax #(.EXP_W(8), .MAN_W(23), .IDX_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(rdy_b), .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(vld_b), .out_ready_i(out_ready), .out_max_o(max_b), .out_idx_o(idx_b),
    .out_nan_o(nan_b), .out_ovf_o(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- frame model (real arithmetic) ----------------
  function automatic bit f_is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real m, v;
    e = int'(b[30:23]);
    m = real'(b[22:0]);
    if (e == 255)    v = 1.0e300;
    else if (e == 0) v = m * (2.0 ** -149.0);
    else             v = (1.0 + m / 8388608.0) * (2.0 ** real'(e - 127));
    return b[31] ? -v : v;
  endfunction

  bit          m_hold = 1'b0;
  logic [31:0] frame[$];
  logic [31:0] e_max = '0;
  logic [7:0]  e_idx_a = '0;
  logic [1:0]  e_idx_b = '0;
  bit          e_nan = 1'b0, e_ovf_a = 1'b0, e_ovf_b = 1'b0;

  task automatic finish_frame();
    int best = -1;
    bit any_nan = 1'b0;
    int n = frame.size();
    foreach (frame[i]) begin
      if (f_is_nan(frame[i])) any_nan = 1'b1;
      else if (best < 0 || f2r(frame[i]) > f2r(frame[best])) best = i;
    end
    e_max   = (best < 0) ? 32'h7FC00000 : frame[best];
    if (best < 0) best = 0;
    e_idx_a = (best > 255) ? 8'hFF : 8'(best);
    e_idx_b = (best > 3) ? 2'd3 : 2'(best);
    e_nan   = any_nan;
    e_ovf_a = (n > 256);
    e_ovf_b = (n > 4);
    frame.delete();
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_hold = 1'b0;
      frame.delete();
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      frame.push_back(in_data);
      if (in_last) begin
        finish_frame();
        m_hold = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready_a", 32'(rdy_a), 32'(!m_hold));
    chk("in_ready_b", 32'(rdy_b), 32'(!m_hold));
    chk("out_valid_a", 32'(vld_a), 32'(m_hold));
    chk("out_valid_b", 32'(vld_b), 32'(m_hold));
    if (m_hold) begin
      chk("out_max_a", max_a, e_max);
      chk("out_idx_a", 32'(idx_a), 32'(e_idx_a));
      chk("out_nan_a", 32'(nan_a), 32'(e_nan));
      chk("out_ovf_a", 32'(ovf_a), 32'(e_ovf_a));
      chk("out_max_b", max_b, e_max);
      chk("out_idx_b", 32'(idx_b), 32'(e_idx_b));
      chk("out_nan_b", 32'(nan_b), 32'(e_nan));
      chk("out_ovf_b", 32'(ovf_b), 32'(e_ovf_b));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] d, input logic last);
    bit ok = 1'b0;
    bit r;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 20; t++) begin
      r = rdy_a;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [31:0] mx, input logic [7:0] ia,
                               input logic [1:0] ib, input bit nan, input bit oa, input bit ob);
    bit seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (vld_a) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_max"}, max_a, mx);
    chk({tag, "_idx_a"}, 32'(idx_a), 32'(ia));
    chk({tag, "_idx_b"}, 32'(idx_b), 32'(ib));
    chk({tag, "_nan"}, 32'(nan_a), 32'(nan));
    chk({tag, "_ovf_a"}, 32'(ovf_a), 32'(oa));
    chk({tag, "_ovf_b"}, 32'(ovf_b), 32'(ob));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(vld_a), 32'd0);
    chk({tag, "_max"}, max_a, 32'd0);
    chk({tag, "_idx"}, 32'(idx_a), 32'd0);
    chk({tag, "_nan"}, 32'(nan_a), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_a), 32'd0);
    chk({tag, "_ready"}, 32'(rdy_a), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ordinary frame, negative loser at the end
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'hC0400000, 1'b1);
    expect_result("t1", 32'h40000000, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0);

    // -0 then +0: tie keeps first, original bits retained
    send(32'h80000000, 1'b0);
    send(32'h00000000, 1'b1);
    expect_result("t2", 32'h80000000, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // NaN consumes index 0, +inf wins
    send(32'h7FC00000, 1'b0);
    send(32'hC0400000, 1'b0);
    send(32'h7F800000, 1'b1);
    expect_result("t3", 32'h7F800000, 8'd2, 2'd2, 1'b1, 1'b0, 1'b0);

    // all-NaN single beats: canonical quiet NaN reported
    send(32'h7FC00000, 1'b1);
    expect_result("t4", 32'h7FC00000, 8'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    send(32'hFF800001, 1'b1);
    expect_result("t4b", 32'h7FC00000, 8'd0, 2'd0, 1'b1, 1'b0, 1'b0);

    // 6 beats: IDX_W=2 instance saturates and flags overflow
    for (int i = 0; i < 5; i++) send(32'h3F800000, 1'b0);
    send(32'h40A00000, 1'b1);
    expect_result("t5", 32'h40A00000, 8'd5, 2'd3, 1'b0, 1'b0, 1'b1);

    // backpressure: result held, in_ready low
    send(32'hBF800000, 1'b0);
    send(32'hC0000000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_ready", 32'(rdy_a), 32'd0);
      chk("hold_max", max_a, 32'hBF800000);
    end
    expect_result("t6", 32'hBF800000, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("ready_after_hs", 32'(rdy_a), 32'd1);

    // back-to-back frame with mixed signs: positive beats a larger-magnitude negative
    send(32'hC0400000, 1'b0);
    send(32'h3F800000, 1'b1);
    expect_result("t7", 32'h3F800000, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0);

    // reset while holding a result
    send(32'h7FC00000, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset mid-frame discards the partial frame
    send(32'h40000000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h3F800000, 1'b1);
    expect_result("t8", 32'h3F800000, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
